// File: rtl/pq_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pq_arb_pkg : shared types and constants for pq_access_arb      |
// | Revision   : 1.0                                               |
// +-----------------------------------------------------------------+
package pq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam int         NREQ     = 3;
  localparam logic [1:0] REQ_ENQ0 = 2'd0;
  localparam logic [1:0] REQ_ENQ1 = 2'd1;
  localparam logic [1:0] REQ_DEQ  = 2'd2;

  // Successor in the fixed ring enq0 -> enq1 -> deq -> enq0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= REQ_DEQ) ? REQ_ENQ0 : idx + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pq_access_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pq_access_arb_if : arbiter <-> priority-queue core bus          |
// | Revision         : 1.0                                          |
// +-----------------------------------------------------------------+
interface pq_access_arb_if #(
  parameter int KW = 8
) ();
  logic          pq_enq;
  logic          pq_deq;
  logic [KW-1:0] pq_ki;
  logic [KW-1:0] pq_ko;
  logic          pq_busy;
  logic          pq_full;
  logic          pq_empty;

  modport master (
    output pq_enq, pq_deq, pq_ki,
    input  pq_ko, pq_busy, pq_full, pq_empty
  );

  modport slave (
    input  pq_enq, pq_deq, pq_ki,
    output pq_ko, pq_busy, pq_full, pq_empty
  );
endinterface
`default_nettype wire

// File: rtl/pq_access_arb_rr_pick3.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_pick3 : combinational 3-way round-robin picker               |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module rr_pick3
  import pq_arb_pkg::*;
(
  input  logic [NREQ-1:0] eligible,
  input  logic [1:0]      ptr,
  output logic            any,
  output logic [1:0]      winner
);

  always_comb begin
    logic [1:0] cand;
    any    = 1'b0;
    winner = REQ_ENQ0;
    cand   = (ptr > REQ_DEQ) ? REQ_ENQ0 : ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && eligible[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
      cand = rr_next(cand);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pq_access_arb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pq_access_arb : round-robin access arbiter for the PQ core      |
// | Optional timeout abort when PQ_ARB_TIMEOUT_EN is defined.       |
// | Revision      : 1.0                                             |
// +-----------------------------------------------------------------+
module pq_access_arb
  import pq_arb_pkg::*;
#(
  parameter int KW      = 8,
  parameter int TMO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_enq,
  input  logic [KW-1:0]   key_in0,
  input  logic [KW-1:0]   key_in1,
  input  logic            req_deq,
  output logic [1:0]      gnt_enq,
  output logic            gnt_deq,
  output logic            deq_valid,
  output logic [KW-1:0]   deq_key,
  pq_access_arb_if.master pq,
  output logic [1:0]      arb_state,
  output logic            err_tmo
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [1:0]      r_rr_ptr;
  logic            r_op_deq;
  logic [NREQ-1:0] w_elig;
  logic            w_any;
  logic [1:0]      w_winner;
  logic            w_issue;
  logic            w_done;
  logic            w_tmo_hit;

  // full and empty together is an illegal core report: grant nobody.
  always_comb begin
    w_elig = '0;
    if (!(pq.pq_full && pq.pq_empty))
      w_elig = {req_deq & ~pq.pq_empty, req_enq & {2{~pq.pq_full}}};
  end

  rr_pick3 u_pick (
    .eligible (w_elig),
    .ptr      (r_rr_ptr),
    .any      (w_any),
    .winner   (w_winner)
  );

`ifdef PQ_ARB_TIMEOUT_EN
  localparam int c_cnt_w = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TMO_CYC - 1);

  logic [c_cnt_w-1:0] r_tmo_cnt;
  logic               r_err_tmo;

  assign w_tmo_hit = (r_state == WAIT) && pq.pq_busy && (r_tmo_cnt == c_tmo_last);
  assign err_tmo   = r_err_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      r_err_tmo <= w_tmo_hit;
      if (r_state == ISSUE)
        r_tmo_cnt <= '0;
      else if (r_state == WAIT)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO_CYC == 0);
  assign w_tmo_hit    = 1'b0;
  assign err_tmo      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ISSUE;
          w_issue     = 1'b1;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (!pq.pq_busy) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= REQ_ENQ0;
      r_op_deq   <= 1'b0;
      gnt_enq    <= '0;
      gnt_deq    <= 1'b0;
      pq.pq_enq  <= 1'b0;
      pq.pq_deq  <= 1'b0;
      pq.pq_ki   <= '0;
      deq_key    <= '0;
      deq_valid  <= 1'b0;
    end else begin
      gnt_enq   <= '0;
      gnt_deq   <= 1'b0;
      pq.pq_enq <= 1'b0;
      pq.pq_deq <= 1'b0;
      deq_valid <= 1'b0;
      if (w_issue) begin
        r_rr_ptr <= rr_next(w_winner);
        r_op_deq <= (w_winner == REQ_DEQ);
        case (w_winner)
          REQ_ENQ0: begin
            gnt_enq   <= 2'b01;
            pq.pq_enq <= 1'b1;
            pq.pq_ki  <= key_in0;
          end
          REQ_ENQ1: begin
            gnt_enq   <= 2'b10;
            pq.pq_enq <= 1'b1;
            pq.pq_ki  <= key_in1;
          end
          default: begin
            gnt_deq   <= 1'b1;
            pq.pq_deq <= 1'b1;
          end
        endcase
      end
      // Result is captured on the WAIT exit edge, so it is valid in the first IDLE cycle.
      if (w_done && r_op_deq) begin
        deq_key   <= pq.pq_ko;
        deq_valid <= 1'b1;
      end
    end
  end

  assign arb_state = r_state;

endmodule
`default_nettype wire
